// File: rtl/pwm_clock_gen.sv
// Programmable-period / programmable-duty waveform generator with a window counter.
// Config is shadowed and only takes effect on period boundaries; all outputs are registered.
module pwm_clock_gen #(
  parameter int CNT_W   = 16,
  parameter int DUR_W   = 32,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   high_time,
  input  logic [DUR_W-1:0]   duration,
  output logic               out_clk,
  output logic               period_tick,
  output logic [COUNT_W-1:0] count,
  output logic               count_wrap,
  output logic               active
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   ph, ph_nxt;
  logic [DUR_W-1:0]   tmr, tmr_nxt;
  logic [CNT_W-1:0]   per_r, per_nxt, high_r, high_nxt;
  logic [DUR_W-1:0]   dur_r, dur_nxt;
  logic [CNT_W-1:0]   pend_per, pend_high;
  logic [DUR_W-1:0]   pend_dur;
  logic               pending, pending_nxt;
  logic               win_done, win_nxt;
  logic [CNT_W-1:0]   cfg_per;
  logic [DUR_W-1:0]   cfg_dur;
  logic               boundary;

  assign cfg_per  = (period < CNT_W'(2)) ? CNT_W'(2) : period;
  assign cfg_dur  = (duration == '0) ? DUR_W'(1) : duration;
  assign boundary = (state == RUN) && (ph >= per_r - CNT_W'(1));

  always_comb begin
    state_nxt   = state;
    ph_nxt      = ph;
    tmr_nxt     = tmr;
    per_nxt     = per_r;
    high_nxt    = high_r;
    dur_nxt     = dur_r;
    pending_nxt = pending;
    win_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_load) begin
          per_nxt     = cfg_per;
          high_nxt    = high_time;
          dur_nxt     = cfg_dur;
          pending_nxt = 1'b0;
        end
        if (en) begin
          state_nxt = RUN;
          ph_nxt    = '0;
          tmr_nxt   = '0;
        end
      end
      RUN: begin
        if (boundary) begin
          ph_nxt = '0;
          // >= keeps the window counter safe if a shorter duration was just applied
          if (tmr >= dur_r - DUR_W'(1)) begin
            tmr_nxt = '0;
            win_nxt = 1'b1;
          end else begin
            tmr_nxt = tmr + DUR_W'(1);
          end
          if (cfg_load) begin
            per_nxt     = cfg_per;
            high_nxt    = high_time;
            dur_nxt     = cfg_dur;
            pending_nxt = 1'b0;
          end else if (pending) begin
            per_nxt     = pend_per;
            high_nxt    = pend_high;
            dur_nxt     = pend_dur;
            pending_nxt = 1'b0;
          end
          if (!en) begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
          end
        end else begin
          ph_nxt = ph + CNT_W'(1);
          if (cfg_load) pending_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ph        <= '0;
      tmr       <= '0;
      per_r     <= CNT_W'(2);
      high_r    <= CNT_W'(1);
      dur_r     <= DUR_W'(1);
      pending   <= 1'b0;
      pend_per  <= CNT_W'(2);
      pend_high <= CNT_W'(1);
      pend_dur  <= DUR_W'(1);
      win_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ph       <= ph_nxt;
      tmr      <= tmr_nxt;
      per_r    <= per_nxt;
      high_r   <= high_nxt;
      dur_r    <= dur_nxt;
      pending  <= pending_nxt;
      win_done <= win_nxt;
      if (cfg_load) begin
        pend_per  <= cfg_per;
        pend_high <= high_time;
        pend_dur  <= cfg_dur;
      end
    end
  end

  // Output stage lags the phase register by one cycle so count lines up with period_tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_clk     <= 1'b0;
      period_tick <= 1'b0;
      active      <= 1'b0;
      count       <= '0;
      count_wrap  <= 1'b0;
    end else begin
      active      <= (state == RUN);
      period_tick <= (state == RUN) && (ph == '0);
      out_clk     <= (state == RUN) && (ph < high_r);
      count_wrap  <= win_done && (&count);
      if (win_done) count <= count + COUNT_W'(1);
    end
  end

endmodule
